// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register in front of the ALU.
// Captures decoded operands under a valid/ready handshake, forwards MEM/WB
// results onto the held source operands, selects PC/immediate operands and
// refreshes the held operands while execute is stalled.
// Optional feature: define ID_EX_PERF_CNT_EN to add saturating
// stall_cycles / flush_count performance counters.

`ifndef XLEN
`define XLEN 32
`endif

module id_ex_stage #(
   parameter int unsigned N            = `XLEN,
   parameter int unsigned REG_IDX_W    = 5,
   parameter logic [3:0]  ALU_CNTL_ADD = 4'b0010
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_pc,
   input  logic [REG_IDX_W-1:0] in_rs1_idx,
   input  logic [REG_IDX_W-1:0] in_rs2_idx,
   input  logic [N-1:0]         in_rs1_data,
   input  logic [N-1:0]         in_rs2_data,
   input  logic [N-1:0]         in_imm,
   input  logic                 in_a_sel_pc,
   input  logic                 in_b_sel_imm,
   input  logic [3:0]           in_alu_control,
   input  logic [REG_IDX_W-1:0] in_rd_idx,
   input  logic                 in_reg_write,
   input  logic                 fwd_mem_wen,
   input  logic [REG_IDX_W-1:0] fwd_mem_rd,
   input  logic [N-1:0]         fwd_mem_data,
   input  logic                 fwd_wb_wen,
   input  logic [REG_IDX_W-1:0] fwd_wb_rd,
   input  logic [N-1:0]         fwd_wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         alu_a,
   output logic [N-1:0]         alu_b,
   output logic [3:0]           alu_control,
   output logic [N-1:0]         out_rs2_data,
   output logic [N-1:0]         out_pc,
   output logic [REG_IDX_W-1:0] out_rd_idx,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count,
`endif
   output logic                 out_reg_write
);

   // Everything the stage holds for one instruction.
   typedef struct packed {
      logic [N-1:0]         pc;
      logic [REG_IDX_W-1:0] rs1_idx;
      logic [REG_IDX_W-1:0] rs2_idx;
      logic [N-1:0]         rs1_data;
      logic [N-1:0]         rs2_data;
      logic [N-1:0]         imm;
      logic                 a_sel_pc;
      logic                 b_sel_imm;
      logic [3:0]           alu_control;
      logic [REG_IDX_W-1:0] rd_idx;
      logic                 reg_write;
   } payload_t;

   // Forwarding mux for one source operand: MEM beats WB, index 0 never forwards.
   function automatic logic [N-1:0] fwd_select(
      input logic [REG_IDX_W-1:0] idx,
      input logic [N-1:0]         held,
      input logic                 mem_wen,
      input logic [REG_IDX_W-1:0] mem_rd,
      input logic [N-1:0]         mem_data,
      input logic                 wb_wen,
      input logic [REG_IDX_W-1:0] wb_rd,
      input logic [N-1:0]         wb_data
   );
      logic [N-1:0] result;
      if (idx == {REG_IDX_W{1'b0}}) begin
         result = held;
      end else if (mem_wen && (mem_rd == idx)) begin
         result = mem_data;
      end else if (wb_wen && (wb_rd == idx)) begin
         result = wb_data;
      end else begin
         result = held;
      end
      return result;
   endfunction

   logic     valid_q;
   logic     valid_d;
   payload_t payload_q;
   payload_t payload_d;
   logic     capture_s;
   logic     in_ready_s;
   logic [N-1:0] fwd_rs1_s;
   logic [N-1:0] fwd_rs2_s;

   assign in_ready_s = !valid_q || out_ready;
   assign capture_s  = in_valid && in_ready_s;

   // Forwarded values of the held source operands.
   always_comb begin
      fwd_rs1_s = fwd_select(payload_q.rs1_idx, payload_q.rs1_data,
                             fwd_mem_wen, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_wen, fwd_wb_rd, fwd_wb_data);
      fwd_rs2_s = fwd_select(payload_q.rs2_idx, payload_q.rs2_data,
                             fwd_mem_wen, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_wen, fwd_wb_rd, fwd_wb_data);
   end

   // Next-state: flush kills, capture loads, stall refreshes, consume drains.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture_s) begin
         valid_d               = 1'b1;
         payload_d.pc          = in_pc;
         payload_d.rs1_idx     = in_rs1_idx;
         payload_d.rs2_idx     = in_rs2_idx;
         payload_d.rs1_data    = in_rs1_data;
         payload_d.rs2_data    = in_rs2_data;
         payload_d.imm         = in_imm;
         payload_d.a_sel_pc    = in_a_sel_pc;
         payload_d.b_sel_imm   = in_b_sel_imm;
         payload_d.alu_control = in_alu_control;
         payload_d.rd_idx      = in_rd_idx;
         payload_d.reg_write   = in_reg_write;
      end else if (valid_q && !out_ready) begin
         // Stalled: fold forwarded values into the held operands so they
         // stay correct once the producer retires out of WB.
         payload_d.rs1_data = fwd_rs1_s;
         payload_d.rs2_data = fwd_rs2_s;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Pipeline register; reset payload is a NOP add of 0 + 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q               <= 1'b0;
         payload_q             <= '0;
         payload_q.alu_control <= ALU_CNTL_ADD;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_count_q;

   // Saturating stall / flush event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         if (valid_q && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end else begin
            stall_cycles_q <= stall_cycles_q;
         end
         if (flush && (valid_q || capture_s) && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_q <= flush_count_q + 32'd1;
         end else begin
            flush_count_q <= flush_count_q;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

   assign in_ready      = in_ready_s;
   assign out_valid     = valid_q;
   assign alu_a         = payload_q.a_sel_pc ? payload_q.pc : fwd_rs1_s;
   assign alu_b         = payload_q.b_sel_imm ? payload_q.imm : fwd_rs2_s;
   assign alu_control   = payload_q.alu_control;
   assign out_rs2_data  = fwd_rs2_s;
   assign out_pc        = payload_q.pc;
   assign out_rd_idx    = payload_q.rd_idx;
   assign out_reg_write = payload_q.reg_write && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (32-bit datapath).
`timescale 1ns/1ps

module tb_id_ex_stage;

   localparam int unsigned N = 32;
   localparam int unsigned RW = 5;
   localparam logic [3:0] ADD = 4'b0010;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready;
   logic [N-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [RW-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
   logic          in_a_sel_pc, in_b_sel_imm, in_reg_write;
   logic [3:0]    in_alu_control;
   logic          fwd_mem_wen, fwd_wb_wen;
   logic [RW-1:0] fwd_mem_rd, fwd_wb_rd;
   logic [N-1:0]  fwd_mem_data, fwd_wb_data;
   logic          out_valid, out_ready, out_reg_write;
   logic [N-1:0]  alu_a, alu_b, out_rs2_data, out_pc;
   logic [3:0]    alu_control;
   logic [RW-1:0] out_rd_idx;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0]   stall_cycles, flush_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.N(N), .REG_IDX_W(RW), .ALU_CNTL_ADD(ADD)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm),
      .in_alu_control(in_alu_control), .in_rd_idx(in_rd_idx),
      .in_reg_write(in_reg_write),
      .fwd_mem_wen(fwd_mem_wen), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_wen(fwd_wb_wen), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd_idx(out_rd_idx),
`ifdef ID_EX_PERF_CNT_EN
      .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
      .out_reg_write(out_reg_write)
   );

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
      in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0;
      in_a_sel_pc = 1'b0; in_b_sel_imm = 1'b0; in_reg_write = 1'b0;
      in_alu_control = ADD;
      fwd_mem_wen = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
      fwd_wb_wen = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      cyc(); cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
      total++; if (alu_a !== 32'h0) begin bad++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
      total++; if (alu_b !== 32'h0) begin bad++; $display("FAIL reset_alu_b got=%h exp=0", alu_b); end
      total++; if (alu_control !== ADD) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", alu_control, ADD); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%h exp=1", in_ready); end
      total++; if (out_reg_write !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%h exp=0", out_reg_write); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_capture();
      in_valid = 1'b1; out_ready = 1'b1;
      in_rs1_idx = 5'd1; in_rs2_idx = 5'd2;
      in_rs1_data = 32'd5; in_rs2_data = 32'd7;
      in_alu_control = ADD; in_rd_idx = 5'd9; in_reg_write = 1'b1;
      cyc();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%h exp=1", out_valid); end
      total++; if (alu_a !== 32'd5) begin bad++; $display("FAIL cap_alu_a got=%h exp=5", alu_a); end
      total++; if (alu_b !== 32'd7) begin bad++; $display("FAIL cap_alu_b got=%h exp=7", alu_b); end
      total++; if (out_rd_idx !== 5'd9) begin bad++; $display("FAIL cap_rd got=%h exp=9", out_rd_idx); end
      total++; if (out_reg_write !== 1'b1) begin bad++; $display("FAIL cap_reg_write got=%h exp=1", out_reg_write); end
      // Stream 4 more: each cycle consumes the held one and captures the next.
      for (int i = 0; i < 4; i++) begin
         in_rs1_data = 32'd10 + 32'(i);
         in_rs2_data = 32'd20 + 32'(i);
         in_alu_control = 4'(i);
         cyc();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%h exp=1", i, out_valid); end
         total++; if (alu_a !== 32'd10 + 32'(i)) begin bad++; $display("FAIL stream_alu_a[%0d] got=%h exp=%h", i, alu_a, 32'd10 + 32'(i)); end
         total++; if (alu_control !== 4'(i)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%h exp=%h", i, alu_control, 4'(i)); end
      end
      in_valid = 1'b0;
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%h exp=0", out_valid); end
      total++; if (out_reg_write !== 1'b0) begin bad++; $display("FAIL drain_reg_write got=%h exp=0", out_reg_write); end
      drive_idle();
   endtask

   task automatic test_forward();
      in_valid = 1'b1; out_ready = 1'b0;
      in_rs1_idx = 5'd3; in_rs1_data = 32'h11;
      cyc();
      in_valid = 1'b0;
      fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
      fwd_wb_wen = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'hBB;
      #1;
      total++; if (alu_a !== 32'hAA) begin bad++; $display("FAIL fwd_mem_prio got=%h exp=000000aa", alu_a); end
      fwd_mem_wen = 1'b0;
      #1;
      total++; if (alu_a !== 32'hBB) begin bad++; $display("FAIL fwd_wb got=%h exp=000000bb", alu_a); end
      fwd_wb_wen = 1'b0;
      #1;
      total++; if (alu_a !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h exp=00000011", alu_a); end
      // Replace with an instruction whose rs1 is x0.
      out_ready = 1'b1; in_valid = 1'b1;
      in_rs1_idx = 5'd0; in_rs1_data = 32'h22;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hAA;
      fwd_wb_wen = 1'b1; fwd_wb_rd = 5'd0; fwd_wb_data = 32'hBB;
      #1;
      total++; if (alu_a !== 32'h22) begin bad++; $display("FAIL fwd_x0 got=%h exp=00000022", alu_a); end
      cyc();
      total++; if (alu_a !== 32'h22) begin bad++; $display("FAIL fwd_x0_refresh got=%h exp=00000022", alu_a); end
      drive_idle();
      out_ready = 1'b1;
      cyc();
      drive_idle();
   endtask

   task automatic test_stall_refresh();
      in_valid = 1'b1; out_ready = 1'b0;
      in_rs2_idx = 5'd4; in_rs2_data = 32'h55;
      cyc();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready0 got=%h exp=0", in_ready); end
      fwd_wb_wen = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h1234;
      #1;
      total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL stall_fwd got=%h exp=00001234", out_rs2_data); end
      cyc();
      fwd_wb_wen = 1'b0; fwd_wb_data = 32'h0;
      #1;
      total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL stall_refresh got=%h exp=00001234", out_rs2_data); end
      total++; if (alu_b !== 32'h1234) begin bad++; $display("FAIL stall_alu_b got=%h exp=00001234", alu_b); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready1 got=%h exp=0", in_ready); end
      cyc();
      total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL stall_hold got=%h exp=00001234", out_rs2_data); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%h exp=1", out_valid); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%h exp=1", in_ready); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_consumed got=%h exp=0", out_valid); end
      drive_idle();
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_rs1_data = 32'h77; in_reg_write = 1'b1; flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%h exp=1", in_ready); end
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_capture got=%h exp=0", out_valid); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_never got=%h exp=0", out_valid); end
      total++; if (out_reg_write !== 1'b0) begin bad++; $display("FAIL flush_reg_write got=%h exp=0", out_reg_write); end
      // Flush while stalled.
      in_valid = 1'b1; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_stall_pre got=%h exp=1", out_valid); end
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stall got=%h exp=0", out_valid); end
      // Reset while stalled.
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_stall got=%h exp=0", out_valid); end
      drive_idle();
   endtask

   task automatic test_imm_pc();
      logic [N-1:0] neg4;
      neg4 = '1;
      neg4[1:0] = 2'b00;
      in_valid = 1'b1; out_ready = 1'b1;
      in_a_sel_pc = 1'b1; in_pc = 32'h100;
      in_b_sel_imm = 1'b1; in_imm = neg4;
      in_rs2_idx = 5'd6; in_rs2_data = 32'h99;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      total++; if (alu_a !== 32'h100) begin bad++; $display("FAIL sel_pc got=%h exp=00000100", alu_a); end
      total++; if (alu_b !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sel_imm got=%h exp=fffffffc", alu_b); end
      total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL out_pc got=%h exp=00000100", out_pc); end
      total++; if (out_rs2_data !== 32'h99) begin bad++; $display("FAIL store_data got=%h exp=00000099", out_rs2_data); end
      out_ready = 1'b1;
      cyc();
      drive_idle();
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_perf();
      drive_idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc(); cyc(); cyc();
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
      out_ready = 1'b1;
      cyc();
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL perf_stall_hold got=%0d exp=3", stall_cycles); end
      flush = 1'b1;
      cyc();
      in_valid = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL perf_flush got=%0d exp=1", flush_count); end
      drive_idle();
   endtask
`endif

   initial begin
      rst = 1'b1;
      test_reset();
      test_capture();
      test_forward();
      test_stall_refresh();
      test_flush();
      test_imm_pc();
`ifdef ID_EX_PERF_CNT_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
